// File: rtl/hid_report_latch.sv
// hid_report_latch: keeps the latest HID keyboard/button state, accumulates
// signed mouse deltas, and freezes a coherent snapshot for the SPI slave at
// the start of every SPI transaction (hid_read rising).
//
// Config macro: HID_LATCH_SATURATE_EN
//   defined   -> accumulator adds saturate at the signed ACC_W limits
//   undefined -> accumulator adds wrap (two's complement, ACC_W bits)
//
// Ports:
//   clk, reset_n                 system clock, async active-low reset
//   hid_read                     async SPI CS level (high = transaction)
//   kbd_connected                keyboard present (level)
//   kbd_report_valid             1-cycle strobe with kbd_modifiers/kbd_keycodes
//   mouse_connected              mouse present (level)
//   mouse_report_valid           1-cycle strobe with mouse_buttons/dx/dy/dwheel
//   hid_keyboard_connected ..
//   hid_mouse_wheel              snapshot presented to the SPI slave
//   snapshot_busy                high while a snapshot is taken/held (SNAP/HOLD)
//   snapshot_count               snapshots taken, wraps 255 -> 0
module hid_report_latch #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DELTA_W     = 8,
  parameter int unsigned ACC_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hid_read,
  input  logic                    kbd_connected,
  input  logic                    kbd_report_valid,
  input  logic [7:0]              kbd_modifiers,
  input  logic [5:0][7:0]         kbd_keycodes,
  input  logic                    mouse_connected,
  input  logic                    mouse_report_valid,
  input  logic [7:0]              mouse_buttons,
  input  logic [DELTA_W-1:0]      mouse_dx,
  input  logic [DELTA_W-1:0]      mouse_dy,
  input  logic [DELTA_W-1:0]      mouse_dwheel,
  output logic                    hid_keyboard_connected,
  output logic                    hid_mouse_connected,
  output logic [7:0]              hid_keyboard_modifiers,
  output logic [5:0][7:0]         hid_keyboard_keycodes,
  output logic [7:0]              hid_mouse_buttons,
  output logic [ACC_W-1:0]        hid_mouse_x,
  output logic [ACC_W-1:0]        hid_mouse_y,
  output logic [ACC_W-1:0]        hid_mouse_wheel,
  output logic                    snapshot_busy,
  output logic [7:0]              snapshot_count
);

  localparam int unsigned N_AXES = 3;
  localparam int unsigned EXT_W  = ACC_W - DELTA_W;

  typedef enum logic [1:0] {IDLE, SNAP, HOLD} state_t;

  state_t                      state, state_next;
  logic [SYNC_STAGES-1:0]      rd_sync;
  logic                        rd_s, rd_s_q, rise;
  logic [7:0]                  live_mods, live_btn;
  logic [5:0][7:0]             live_keys;
  logic [N_AXES-1:0][ACC_W-1:0] acc, acc_next, delta_ext;

  // Add with optional saturation at the signed ACC_W range.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] d);
    logic [ACC_W-1:0] s;
    s = a + d;
`ifdef HID_LATCH_SATURATE_EN
    // Overflow only when both operands share a sign and the result flips it.
    if ((a[ACC_W-1] == d[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]))
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s;
  endfunction

  // hid_read synchronizer plus one extra flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync <= '0;
      rd_s_q  <= 1'b0;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], hid_read};
      rd_s_q  <= rd_sync[SYNC_STAGES-1];
    end
  end

  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign rise = rd_s & ~rd_s_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = SNAP;
      SNAP:    state_next = HOLD;
      HOLD:    if (!rd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign-extended per-report deltas.
  always_comb begin
    delta_ext[0] = {{EXT_W{mouse_dx[DELTA_W-1]}},     mouse_dx};
    delta_ext[1] = {{EXT_W{mouse_dy[DELTA_W-1]}},     mouse_dy};
    delta_ext[2] = {{EXT_W{mouse_dwheel[DELTA_W-1]}}, mouse_dwheel};
  end

  // Accumulator update: disconnect clears, SNAP restarts from the same-cycle
  // delta so a report coinciding with the snapshot is carried into the next one.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < N_AXES; i++) begin
      if (!mouse_connected)
        acc_next[i] = '0;
      else if (state == SNAP)
        acc_next[i] = mouse_report_valid ? delta_ext[i] : '0;
      else if (mouse_report_valid)
        acc_next[i] = acc_add(acc[i], delta_ext[i]);
    end
  end

  // Live keyboard/mouse state and accumulators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_mods <= '0;
      live_keys <= '0;
      live_btn  <= '0;
      acc       <= '0;
    end else begin
      if (!kbd_connected) begin
        live_mods <= '0;
        live_keys <= '0;
      end else if (kbd_report_valid) begin
        live_mods <= kbd_modifiers;
        live_keys <= kbd_keycodes;
      end
      if (!mouse_connected)        live_btn <= '0;
      else if (mouse_report_valid) live_btn <= mouse_buttons;
      acc <= acc_next;
    end
  end

  // Snapshot registers: loaded from pre-update live values in SNAP only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hid_keyboard_connected <= 1'b0;
      hid_mouse_connected    <= 1'b0;
      hid_keyboard_modifiers <= '0;
      hid_keyboard_keycodes  <= '0;
      hid_mouse_buttons      <= '0;
      hid_mouse_x            <= '0;
      hid_mouse_y            <= '0;
      hid_mouse_wheel        <= '0;
      snapshot_count         <= '0;
      snapshot_busy          <= 1'b0;
    end else begin
      snapshot_busy <= (state_next != IDLE);
      if (state == SNAP) begin
        hid_keyboard_connected <= kbd_connected;
        hid_mouse_connected    <= mouse_connected;
        hid_keyboard_modifiers <= live_mods;
        hid_keyboard_keycodes  <= live_keys;
        hid_mouse_buttons      <= live_btn;
        hid_mouse_x            <= acc[0];
        hid_mouse_y            <= acc[1];
        hid_mouse_wheel        <= acc[2];
        snapshot_count         <= snapshot_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hid_report_latch.sv
// Bench for hid_report_latch: reset, table-driven snapshot vectors, SNAP-cycle
// strobe, accumulator limit (10-bit instance), randomized traffic against a
// transaction-level model, reset during HOLD and counter wrap.
module tb_hid_report_latch;

  localparam int unsigned SMALL_W = 10;

  logic clk, reset_n, hid_read;
  logic kbd_connected, kbd_report_valid, mouse_connected, mouse_report_valid;
  logic [7:0] kbd_modifiers, mouse_buttons;
  logic [5:0][7:0] kbd_keycodes;
  logic [7:0] mouse_dx, mouse_dy, mouse_dwheel;

  logic hid_keyboard_connected, hid_mouse_connected, snapshot_busy;
  logic [7:0] hid_keyboard_modifiers, hid_mouse_buttons, snapshot_count;
  logic [5:0][7:0] hid_keyboard_keycodes;
  logic [31:0] hid_mouse_x, hid_mouse_y, hid_mouse_wheel;

  logic s_kc, s_mc, s_busy;
  logic [7:0] s_mods, s_btn, s_count;
  logic [5:0][7:0] s_keys;
  logic [SMALL_W-1:0] s_x, s_y, s_w;

  hid_report_latch u_dut (
    .clk(clk), .reset_n(reset_n), .hid_read(hid_read),
    .kbd_connected(kbd_connected), .kbd_report_valid(kbd_report_valid),
    .kbd_modifiers(kbd_modifiers), .kbd_keycodes(kbd_keycodes),
    .mouse_connected(mouse_connected), .mouse_report_valid(mouse_report_valid),
    .mouse_buttons(mouse_buttons), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .mouse_dwheel(mouse_dwheel),
    .hid_keyboard_connected(hid_keyboard_connected),
    .hid_mouse_connected(hid_mouse_connected),
    .hid_keyboard_modifiers(hid_keyboard_modifiers),
    .hid_keyboard_keycodes(hid_keyboard_keycodes),
    .hid_mouse_buttons(hid_mouse_buttons), .hid_mouse_x(hid_mouse_x),
    .hid_mouse_y(hid_mouse_y), .hid_mouse_wheel(hid_mouse_wheel),
    .snapshot_busy(snapshot_busy), .snapshot_count(snapshot_count)
  );

  hid_report_latch #(.ACC_W(SMALL_W)) u_small (
    .clk(clk), .reset_n(reset_n), .hid_read(hid_read),
    .kbd_connected(kbd_connected), .kbd_report_valid(kbd_report_valid),
    .kbd_modifiers(kbd_modifiers), .kbd_keycodes(kbd_keycodes),
    .mouse_connected(mouse_connected), .mouse_report_valid(mouse_report_valid),
    .mouse_buttons(mouse_buttons), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .mouse_dwheel(mouse_dwheel),
    .hid_keyboard_connected(s_kc), .hid_mouse_connected(s_mc),
    .hid_keyboard_modifiers(s_mods), .hid_keyboard_keycodes(s_keys),
    .hid_mouse_buttons(s_btn), .hid_mouse_x(s_x), .hid_mouse_y(s_y),
    .hid_mouse_wheel(s_w), .snapshot_busy(s_busy), .snapshot_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: live values, unbounded accumulators folded to width.
  logic [7:0]      m_mods, m_btn;
  logic [5:0][7:0] m_keys;
  longint          a32 [3];
  longint          a10 [3];
  logic            e_kc, e_mc;
  logic [7:0]      e_mods, e_btn, e_count;
  logic [5:0][7:0] e_keys;
  longint          e32 [3];
  longint          e10 [3];

  typedef struct {
    logic kc; logic mc; logic [7:0] mods; logic [7:0] key0; logic [7:0] btn;
    int d0; int d1; int d2; int dy;
    longint ex; longint ey; logic [7:0] emods; logic [7:0] ekey0;
    logic [7:0] ebtn; logic ekc; logic emc; int ecount;
  } vec_t;
  vec_t tbl [5];

  function automatic longint madd(longint a, longint d, int w);
    longint lim, s;
    lim = longint'(1) <<< (w - 1);
    s = a + d;
`ifdef HID_LATCH_SATURATE_EN
    if (s > lim - 1) s = lim - 1;
    if (s < -lim)    s = -lim;
`else
    if (s > lim - 1) s = s - 2 * lim;
    if (s < -lim)    s = s + 2 * lim;
`endif
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mods = '0; m_btn = '0; m_keys = '0;
    e_kc = 1'b0; e_mc = 1'b0; e_mods = '0; e_btn = '0; e_keys = '0;
    e_count = '0;
    for (int i = 0; i < 3; i++) begin
      a32[i] = 0; a10[i] = 0; e32[i] = 0; e10[i] = 0;
    end
  endtask

  // Snapshot event: freeze live values, restart accumulation.
  task automatic model_snap();
    e_kc = kbd_connected; e_mc = mouse_connected;
    e_mods = m_mods; e_keys = m_keys; e_btn = m_btn;
    for (int i = 0; i < 3; i++) begin
      e32[i] = a32[i]; e10[i] = a10[i]; a32[i] = 0; a10[i] = 0;
    end
    e_count = e_count + 8'd1;
  endtask

  // One clock: drive at negedge, model the posedge, return at next negedge.
  task automatic cycle(input logic kv, input logic mv, input logic [7:0] dx,
                       input logic [7:0] dy, input logic [7:0] dw,
                       input logic [7:0] mods, input logic [5:0][7:0] keys,
                       input logic [7:0] btn);
    longint d [3];
    kbd_report_valid = kv; kbd_modifiers = mods; kbd_keycodes = keys;
    mouse_report_valid = mv; mouse_dx = dx; mouse_dy = dy; mouse_dwheel = dw;
    mouse_buttons = btn;
    @(negedge clk);
    d[0] = longint'($signed(dx)); d[1] = longint'($signed(dy));
    d[2] = longint'($signed(dw));
    if (!kbd_connected) begin
      m_mods = '0; m_keys = '0;
    end else if (kv) begin
      m_mods = mods; m_keys = keys;
    end
    if (!mouse_connected) begin
      m_btn = '0;
      for (int i = 0; i < 3; i++) begin a32[i] = 0; a10[i] = 0; end
    end else if (mv) begin
      m_btn = btn;
      for (int i = 0; i < 3; i++) begin
        a32[i] = madd(a32[i], d[i], 32);
        a10[i] = madd(a10[i], d[i], SMALL_W);
      end
    end
    kbd_report_valid = 1'b0; mouse_report_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 48'd0, 8'd0);
  endtask

  task automatic rand_mouse();
    cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'd0, 48'd0,
          8'($urandom));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (snapshot_busy && n < 10) begin
      idle();
      n++;
    end
    chk("busy_release", longint'(snapshot_busy), 0);
    idle();
  endtask

  // Full transaction: CS high for `hold` clocks plus `extra` strobes in HOLD.
  task automatic snap(input int hold, input int extra);
    hid_read = 1'b1;
    model_snap();
    repeat (hold) idle();
    chk("busy_in_hold", longint'(snapshot_busy), 1);
    repeat (extra) rand_mouse();
    hid_read = 1'b0;
    wait_idle();
  endtask

  task automatic check_snap(input string tag);
    chk({tag, "_kconn"}, longint'(hid_keyboard_connected), longint'(e_kc));
    chk({tag, "_mconn"}, longint'(hid_mouse_connected), longint'(e_mc));
    chk({tag, "_mods"}, longint'(hid_keyboard_modifiers), longint'(e_mods));
    chk({tag, "_keys"}, longint'(hid_keyboard_keycodes), longint'(e_keys));
    chk({tag, "_btn"}, longint'(hid_mouse_buttons), longint'(e_btn));
    chk({tag, "_x"}, longint'($signed(hid_mouse_x)), e32[0]);
    chk({tag, "_y"}, longint'($signed(hid_mouse_y)), e32[1]);
    chk({tag, "_w"}, longint'($signed(hid_mouse_wheel)), e32[2]);
    chk({tag, "_count"}, longint'(snapshot_count), longint'(e_count));
    chk({tag, "_small_y"}, longint'($signed(s_y)), e10[1]);
    chk({tag, "_small_w"}, longint'($signed(s_w)), e10[2]);
  endtask

  initial begin
    int lat;
    logic [5:0][7:0] keys;

    tbl[0] = '{1'b1, 1'b1, 8'h02, 8'h04, 8'h01, 5, -2, 10, 1,
               13, 3, 8'h02, 8'h04, 8'h01, 1'b1, 1'b1, 1};
    tbl[1] = '{1'b1, 1'b1, 8'h11, 8'h2A, 8'h03, -128, -128, 127, -1,
               -129, -3, 8'h11, 8'h2A, 8'h03, 1'b1, 1'b1, 2};
    tbl[2] = '{1'b0, 1'b1, 8'h02, 8'h04, 8'h02, 0, 0, 0, 0,
               0, 0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1, 3};
    tbl[3] = '{1'b1, 1'b0, 8'h55, 8'h3F, 8'hFF, 7, 7, 7, 7,
               0, 0, 8'h55, 8'h3F, 8'h00, 1'b1, 1'b0, 4};
    tbl[4] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h80, 100, 100, 100, -50,
               300, -150, 8'h00, 8'h00, 8'h80, 1'b1, 1'b1, 5};

    reset_n = 1'b0; hid_read = 1'b0;
    kbd_connected = 1'b1; mouse_connected = 1'b1;
    kbd_report_valid = 1'b0; mouse_report_valid = 1'b0;
    kbd_modifiers = '0; kbd_keycodes = '0; mouse_buttons = '0;
    mouse_dx = '0; mouse_dy = '0; mouse_dwheel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_snap("reset");
    chk("reset_busy", longint'(snapshot_busy), 0);
    reset_n = 1'b1;
    idle();

    // Table vectors: one report burst then one transaction per row.
    for (int r = 0; r < 5; r++) begin
      kbd_connected = tbl[r].kc; mouse_connected = tbl[r].mc;
      repeat (2) idle();
      keys = '0; keys[0] = tbl[r].key0;
      cycle(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, tbl[r].mods, keys, 8'd0);
      cycle(1'b0, 1'b1, 8'(tbl[r].d0), 8'(tbl[r].dy), 8'(tbl[r].d0), 8'd0, 48'd0, tbl[r].btn);
      cycle(1'b0, 1'b1, 8'(tbl[r].d1), 8'(tbl[r].dy), 8'(tbl[r].d1), 8'd0, 48'd0, tbl[r].btn);
      cycle(1'b0, 1'b1, 8'(tbl[r].d2), 8'(tbl[r].dy), 8'(tbl[r].d2), 8'd0, 48'd0, tbl[r].btn);
      snap(10, 0);
      chk("tbl_x", longint'($signed(hid_mouse_x)), tbl[r].ex);
      chk("tbl_y", longint'($signed(hid_mouse_y)), tbl[r].ey);
      chk("tbl_w", longint'($signed(hid_mouse_wheel)), tbl[r].ex);
      chk("tbl_mods", longint'(hid_keyboard_modifiers), longint'(tbl[r].emods));
      chk("tbl_key0", longint'(hid_keyboard_keycodes[0]), longint'(tbl[r].ekey0));
      chk("tbl_btn", longint'(hid_mouse_buttons), longint'(tbl[r].ebtn));
      chk("tbl_kconn", longint'(hid_keyboard_connected), longint'(tbl[r].ekc));
      chk("tbl_mconn", longint'(hid_mouse_connected), longint'(tbl[r].emc));
      chk("tbl_count", longint'(snapshot_count), longint'(tbl[r].ecount));
      check_snap("tbl_model");
    end
    kbd_connected = 1'b1; mouse_connected = 1'b1;
    idle();

    // Strobe landing in the SNAP cycle belongs to the next snapshot.
    cycle(1'b0, 1'b1, 8'd4, 8'd0, 8'd0, 8'd0, 48'd0, 8'd0);
    hid_read = 1'b1;
    lat = 0;
    while (!snapshot_busy && lat < 10) begin
      idle();
      lat++;
    end
    chk("snap_entry_latency", longint'(lat), 3);
    model_snap();
    cycle(1'b0, 1'b1, 8'd7, 8'd0, 8'd0, 8'd0, 48'd0, 8'd0);
    chk("snap_cycle_x", longint'($signed(hid_mouse_x)), 4);
    repeat (3) idle();
    hid_read = 1'b0;
    wait_idle();
    check_snap("snap_cycle");
    snap(6, 0);
    chk("after_snap_cycle_x", longint'($signed(hid_mouse_x)), 7);
    check_snap("after_snap_cycle");

    // Accumulator limit on the 10-bit instance: 503 + 127 exceeds 511.
    cycle(1'b0, 1'b1, 8'd0, 8'd127, 8'd0, 8'd0, 48'd0, 8'd0);
    cycle(1'b0, 1'b1, 8'd0, 8'd127, 8'd0, 8'd0, 48'd0, 8'd0);
    cycle(1'b0, 1'b1, 8'd0, 8'd127, 8'd0, 8'd0, 48'd0, 8'd0);
    cycle(1'b0, 1'b1, 8'd0, 8'd122, 8'd0, 8'd0, 48'd0, 8'd0);
    cycle(1'b0, 1'b1, 8'd0, 8'd127, 8'd0, 8'd0, 48'd0, 8'd0);
    snap(6, 0);
`ifdef HID_LATCH_SATURATE_EN
    chk("limit_small_y", longint'($signed(s_y)), 511);
`else
    chk("limit_small_y", longint'($signed(s_y)), -394);
`endif
    chk("limit_main_y", longint'($signed(hid_mouse_y)), 630);
    check_snap("limit");

    // Randomized traffic, including disconnects and strobes during HOLD.
    for (int it = 0; it < 40; it++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 9) == 0) kbd_connected = ~kbd_connected;
        if ($urandom_range(0, 9) == 0) mouse_connected = ~mouse_connected;
        keys = 48'({$urandom(), $urandom()});
        cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), keys,
              8'($urandom));
      end
      snap(6, int'($urandom_range(0, 3)));
      check_snap("rand");
    end
    kbd_connected = 1'b1; mouse_connected = 1'b1;
    idle();

    // Reset asserted during HOLD with CS still high.
    hid_read = 1'b1;
    model_snap();
    repeat (6) idle();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_snap("in_reset");
    chk("in_reset_busy", longint'(snapshot_busy), 0);
    reset_n = 1'b1;
    model_snap();
    repeat (6) idle();
    hid_read = 1'b0;
    wait_idle();
    check_snap("post_reset");
    chk("post_reset_count", longint'(snapshot_count), 1);

    // Counter wrap: 255 more transactions bring it back to zero.
    for (int p = 0; p < 255; p++) snap(5, 0);
    chk("count_wrap", longint'(snapshot_count), 0);
    check_snap("wrap");

    // A one-clock CS pulse yields at most one snapshot.
    hid_read = 1'b1;
    idle();
    hid_read = 1'b0;
    repeat (8) idle();
    chk("short_pulse", longint'(snapshot_count <= 8'd1), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
